pet_kbd_scanner: RTL and testbench

- Sequences the PET real-keyboard matrix: selects each of the 10 KEYROW lines in turn, samples the 8 KEYCOL lines, and debounces each row.
- Holds a 10x8 debounced key matrix that the PIA keyboard port reads by row number.
- Sits between the board keyboard pins (top-level tristate buffers) and the PET PIA1 emulation, replacing direct pin sampling by the CPU.

---
 rtl/pet_kbd_pkg.sv | 15 +
 rtl/pet_kbd_row_debounce.sv | 46 ++++
 rtl/pet_kbd_scanner.sv | 116 +++++++++++
 tb/tb_pet_kbd_scanner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pet_kbd_pkg.sv
// Shared constants and FSM state type for the PET keyboard matrix scanner.
package pet_kbd_pkg;

  localparam int NUM_ROWS = 10;
  localparam int NUM_COLS = 8;
  localparam int ROW_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    GAP
  } scan_state_t;

endpackage

// File: rtl/pet_kbd_row_debounce.sv
// Debounces one keyboard row: a new column byte must be seen on
// DEBOUNCE_SCANS consecutive scans of this row before it is committed.
module pet_kbd_row_debounce
  import pet_kbd_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_valid,
  input  logic [NUM_COLS-1:0] s,
  output logic [NUM_COLS-1:0] row_q
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [NUM_COLS-1:0] cand, cand_next;
  logic [CW-1:0]       cnt, cnt_next;

  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (s != cand) begin
      cand_next = s;
      cnt_next  = CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CW'(1);
    end
  end

  // The committed row is rewritten on every sample while the count is saturated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand  <= '1;
      cnt   <= '0;
      row_q <= '1;
    end else if (sample_valid) begin
      cand <= cand_next;
      cnt  <= cnt_next;
      if (cnt_next == CNT_MAX)
        row_q <= cand_next;
    end
  end

endmodule

// File: rtl/pet_kbd_scanner.sv
// PET keyboard matrix scanner: drives each KEYROW in turn, samples KEYCOL,
// debounces per row and serves the debounced matrix to the PIA by row index.
module pet_kbd_scanner
  import pet_kbd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                scan_en,
  input  logic [NUM_COLS-1:0] keycol_in,
  output logic [NUM_ROWS-1:0] keyrow_oe,
  input  logic [ROW_W-1:0]    pia_row,
  output logic [NUM_COLS-1:0] pia_col,
  output logic                scan_done,
  output logic                any_key
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  scan_state_t         state, next_state;
  logic [SW-1:0]       settle_cnt;
  logic [ROW_W-1:0]    row_idx;
  logic [NUM_COLS-1:0] sync1, sync2;
  logic [NUM_COLS-1:0] matrix [NUM_ROWS];
  logic [NUM_COLS-1:0] read_byte;
  logic                all_open;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keycol_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      row_idx    <= '0;
    end else begin
      state <= next_state;
      if (state == DRIVE && settle_cnt != SETTLE_LAST)
        settle_cnt <= settle_cnt + SW'(1);
      else
        settle_cnt <= '0;
      if (state == GAP)
        row_idx <= (row_idx == ROW_W'(NUM_ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
    end
  end

  // Rows are only released in GAP, so the top never drives two rows at once.
  always_comb begin
    next_state = state;
    keyrow_oe  = '0;
    scan_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (scan_en)
          next_state = DRIVE;
      end
      DRIVE: begin
        keyrow_oe[row_idx] = 1'b1;
        if (settle_cnt == SETTLE_LAST)
          next_state = SAMPLE;
      end
      SAMPLE: begin
        keyrow_oe[row_idx] = 1'b1;
        next_state         = GAP;
      end
      GAP: begin
        scan_done  = (row_idx == ROW_W'(NUM_ROWS - 1));
        next_state = scan_en ? DRIVE : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    pet_kbd_row_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_valid(state == SAMPLE && row_idx == ROW_W'(r)),
      .s           (sync2),
      .row_q       (matrix[r])
    );
  end

  always_comb begin
    read_byte = '1;
    all_open  = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (pia_row == ROW_W'(r))
        read_byte = matrix[r];
      all_open = all_open & (&matrix[r]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pia_col <= '1;
      any_key <= 1'b0;
    end else begin
      pia_col <= read_byte;
      any_key <= ~all_open;
    end
  end

endmodule

// File: tb/tb_pet_kbd_scanner.sv
// Directed bench for pet_kbd_scanner with a short settle time; expected
// row timing, debounce commits and PIA reads are worked out by hand.
module tb_pet_kbd_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_en;
  logic [7:0] keycol_in;
  logic [9:0] keyrow_oe;
  logic [3:0] pia_row;
  logic [7:0] pia_col;
  logic       scan_done;
  logic       any_key;
  logic       key_down;

  int assert_count = 0;
  int fail_count   = 0;

  always #5 clk = ~clk;

  // Row 3 / column 5 switch: pulls the column low only while row 3 is driven.
  assign keycol_in = (key_down && keyrow_oe[3]) ? 8'hDF : 8'hFF;

  pet_kbd_scanner #(
    .SETTLE_CYCLES (8),
    .DEBOUNCE_SCANS(4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_en  (scan_en),
    .keycol_in(keycol_in),
    .keyrow_oe(keyrow_oe),
    .pia_row  (pia_row),
    .pia_col  (pia_col),
    .scan_done(scan_done),
    .any_key  (any_key)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic key, input logic [3:0] row);
    scan_en  = en;
    key_down = key;
    pia_row  = row;
  endtask

  // Cycle k counts negedges since scan_en first rose; scanning pauses 2271..2280.
  function automatic int schedPos(input int k);
    if (k >= 2271 && k <= 2280) return -1;
    return (k <= 2270) ? (k - 1) % 10 : (k - 2281) % 10;
  endfunction

  function automatic int schedRow(input int k);
    return (k <= 2270) ? ((k - 1) / 10) % 10 : (7 + (k - 2281) / 10) % 10;
  endfunction

  function automatic logic [9:0] expOe(input int k);
    int pos = schedPos(k);
    if (pos < 0 || pos == 9) return '0;
    return 10'(1 << schedRow(k));
  endfunction

  function automatic logic expDone(input int k);
    return schedPos(k) == 9 && schedRow(k) == 9;
  endfunction

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd3);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_oe", keyrow_oe, 10'h000);
      checkOutput("idle_pia_col", pia_col, 8'hFF);
      checkOutput("idle_any_key", any_key, 1'b0);
      checkOutput("idle_scan_done", scan_done, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 4'd3);
    for (int k = 1; k <= 2313; k++) begin
      @(negedge clk);
      checkOutput("keyrow_oe", keyrow_oe, expOe(k));
      checkOutput("scan_done", scan_done, expDone(k));

      if (k == 190) applyStimulus(1'b1, 1'b0, 4'd0);
      if (k == 191) begin
        checkOutput("row0_open", pia_col, 8'hFF);
        applyStimulus(1'b1, 1'b0, 4'd9);
      end
      if (k == 192) begin
        checkOutput("row9_open", pia_col, 8'hFF);
        applyStimulus(1'b1, 1'b0, 4'd3);
      end
      if (k == 200) begin
        checkOutput("row3_open", pia_col, 8'hFF);
        checkOutput("any_key_open", any_key, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'd3);
      end
      if (k == 439) checkOutput("press_3_scans", pia_col, 8'hFF);
      if (k == 539) checkOutput("press_pre_commit", pia_col, 8'hFF);
      if (k == 540) begin
        checkOutput("press_commit_cycle", pia_col, 8'hFF);
        checkOutput("press_any_key_lag", any_key, 1'b0);
      end
      if (k == 541) begin
        checkOutput("press_committed", pia_col, 8'hDF);
        checkOutput("press_any_key", any_key, 1'b1);
      end
      if (k == 545) applyStimulus(1'b1, 1'b1, 4'd4);
      if (k == 546) begin
        checkOutput("row4_other", pia_col, 8'hFF);
        applyStimulus(1'b1, 1'b1, 4'd12);
      end
      if (k == 547) begin
        checkOutput("row12_invalid", pia_col, 8'hFF);
        applyStimulus(1'b1, 1'b1, 4'd3);
      end
      if (k == 548) checkOutput("row3_reread", pia_col, 8'hDF);
      if (k == 600) applyStimulus(1'b1, 1'b0, 4'd3);
      if (k == 939) checkOutput("release_pre_commit", pia_col, 8'hDF);
      if (k == 940) checkOutput("release_commit_cycle", pia_col, 8'hDF);
      if (k == 941) begin
        checkOutput("release_committed", pia_col, 8'hFF);
        checkOutput("release_any_key", any_key, 1'b0);
      end
      if (k >= 1000 && k <= 1800 && k % 100 == 0)
        applyStimulus(1'b1, logic'((k / 100) % 2 == 0), 4'd3);
      if (k >= 1050 && k <= 2050 && k % 100 == 50)
        checkOutput("bounce_row3", pia_col, 8'hFF);
      if (k == 2139) checkOutput("held_pre_commit", pia_col, 8'hFF);
      if (k == 2141) begin
        checkOutput("held_committed", pia_col, 8'hDF);
        checkOutput("held_any_key", any_key, 1'b1);
      end
      if (k == 2263) applyStimulus(1'b0, 1'b1, 4'd3);
      if (k == 2280) applyStimulus(1'b1, 1'b1, 4'd3);
      if (k == 2313) begin
        checkOutput("pre_reset_col", pia_col, 8'hDF);
        checkOutput("pre_reset_any_key", any_key, 1'b1);
      end
    end

    // Asynchronous reset in the middle of a row-0 DRIVE.
    reset_n = 1'b0;
    #1;
    checkOutput("reset_oe", keyrow_oe, 10'h000);
    checkOutput("reset_pia_col", pia_col, 8'hFF);
    checkOutput("reset_any_key", any_key, 1'b0);
    checkOutput("reset_scan_done", scan_done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("restart_oe", keyrow_oe, (i <= 9) ? 10'h001 : 10'h000);
      checkOutput("restart_pia_col", pia_col, 8'hFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
